// File: rtl/video_in_pack.sv
// Video capture front end: samples the camera-side pixel stream, packs
// PIX_PER_WORD pixels per word (first pixel in the MSBs) and emits one-cycle
// write strobes towards the video_in FIFO. It also tracks frame lock and flags
// geometry errors and words dropped on FIFO back-pressure.
//
// Optional feature: define VIDEO_IN_ERR_CNT_EN to build the saturating error
// counter. When it is undefined, err_cnt is tied to zero.
//
// Ports:
//   clk          single clock, rising edge
//   RST          synchronous active-high reset
//   line_valid   line active qualifier
//   frame_valid  frame active qualifier
//   pixel_in     pixel data, sampled when both qualifiers are high
//   fifo_full    FIFO cannot accept a write this cycle
//   data_out     packed word, held between strobes
//   w_e          one-cycle write strobe qualifying data_out
//   line_err     pulse: closed line length differs from P_WIDTH
//   frame_err    pulse: line count differs from P_HEIGHT at frame end
//   drop         pulse: completed word discarded because fifo_full was high
//   frame_done   pulse at every frame end
//   err_cnt      saturating count of cycles with any error pulse
module video_in_pack #(
  parameter int unsigned P_WIDTH      = 640,
  parameter int unsigned P_HEIGHT     = 480,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned PIX_PER_WORD = 4
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          line_valid,
  input  logic                          frame_valid,
  input  logic [PIX_W-1:0]              pixel_in,
  input  logic                          fifo_full,
  output logic [PIX_W*PIX_PER_WORD-1:0] data_out,
  output logic                          w_e,
  output logic                          line_err,
  output logic                          frame_err,
  output logic                          drop,
  output logic                          frame_done,
  output logic [15:0]                   err_cnt
);

  localparam int unsigned PIX_CW  = $clog2(P_WIDTH + 1);
  // Line counter saturates at P_HEIGHT+1, so it must be able to hold that value.
  localparam int unsigned LINE_CW = $clog2(P_HEIGHT + 2);
  localparam int unsigned SLOT_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [PIX_CW-1:0]  PIX_MAX   = PIX_CW'(P_WIDTH);
  localparam logic [LINE_CW-1:0] LINE_MAX  = LINE_CW'(P_HEIGHT);
  localparam logic [LINE_CW-1:0] LINE_SAT  = LINE_CW'(P_HEIGHT + 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  typedef logic [PIX_PER_WORD-1:0][PIX_W-1:0] word_t;

  state_e             state_q;
  logic               lv_q;
  logic               fv_q;
  logic [PIX_CW-1:0]  pix_c_q;
  logic [LINE_CW-1:0] line_c_q;
  logic [SLOT_W-1:0]  slot_q;
  logic               line_bad_q;
  word_t              lanes_q;
  word_t              data_q;
  logic               w_e_q;
  logic               line_err_q;
  logic               frame_err_q;
  logic               drop_q;
  logic               frame_done_q;

  logic               active_c;
  logic               pix_valid_c;
  logic               accept_c;
  logic               reject_c;
  logic               slot_last_c;
  logic               line_end_c;
  logic               frame_end_c;
  logic               close_line_c;
  logic [LINE_CW-1:0] line_c_inc_c;
  logic [LINE_CW-1:0] lines_final_c;
  logic [SLOT_W-1:0]  lane_idx_c;
  word_t              word_c;

  // Per-cycle qualifier decode, edge detection and lane insertion.
  always_comb begin
    active_c     = (state_q == ACTIVE);
    pix_valid_c  = active_c && line_valid && frame_valid;
    // Pixels past the line width, or on lines past the frame height, are discarded.
    accept_c     = pix_valid_c && (pix_c_q < PIX_MAX) && (line_c_q < LINE_MAX);
    reject_c     = pix_valid_c && !accept_c;
    slot_last_c  = (slot_q == SLOT_LAST);
    line_end_c   = active_c && lv_q && !line_valid && frame_valid;
    frame_end_c  = active_c && fv_q && !frame_valid;
    // A line still open when the frame ends is closed together with the frame.
    close_line_c = line_end_c || (frame_end_c && lv_q);
    line_c_inc_c = (line_c_q == LINE_SAT) ? LINE_SAT : line_c_q + LINE_CW'(1);
    lines_final_c = close_line_c ? line_c_inc_c : line_c_q;
    // Slot 0 goes to the most significant lane.
    lane_idx_c   = SLOT_LAST - slot_q;
    word_c       = lanes_q;
    word_c[lane_idx_c] = pixel_in;
  end

  // Frame-lock state machine, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= SYNC;
      lv_q         <= 1'b0;
      fv_q         <= 1'b0;
      pix_c_q      <= '0;
      line_c_q     <= '0;
      slot_q       <= '0;
      line_bad_q   <= 1'b0;
      lanes_q      <= '0;
      data_q       <= '0;
      w_e_q        <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      drop_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      lv_q         <= line_valid;
      fv_q         <= frame_valid;
      w_e_q        <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      drop_q       <= 1'b0;
      frame_done_q <= 1'b0;

      case (state_q)
        SYNC: begin
          // Never lock onto a frame that was already running.
          if (!frame_valid) begin
            state_q <= IDLE;
          end
        end

        IDLE: begin
          if (frame_valid && !fv_q) begin
            state_q    <= ACTIVE;
            pix_c_q    <= '0;
            line_c_q   <= '0;
            slot_q     <= '0;
            line_bad_q <= 1'b0;
          end
        end

        ACTIVE: begin
          if (accept_c) begin
            lanes_q <= word_c;
            pix_c_q <= pix_c_q + PIX_CW'(1);
            slot_q  <= slot_last_c ? '0 : slot_q + SLOT_W'(1);
            if (slot_last_c) begin
              // No stall path: a full FIFO costs the whole word.
              if (fifo_full) begin
                drop_q <= 1'b1;
              end else begin
                w_e_q  <= 1'b1;
                data_q <= word_c;
              end
            end
          end

          if (reject_c) begin
            line_bad_q <= 1'b1;
          end

          // Any partial word is abandoned when the line closes.
          if (close_line_c) begin
            line_err_q <= line_bad_q || (pix_c_q != PIX_MAX);
            pix_c_q    <= '0;
            slot_q     <= '0;
            line_bad_q <= 1'b0;
            line_c_q   <= line_c_inc_c;
          end

          if (frame_end_c) begin
            frame_done_q <= 1'b1;
            frame_err_q  <= (lines_final_c != LINE_MAX);
            state_q      <= IDLE;
          end
        end

        default: begin
          state_q <= SYNC;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign w_e        = w_e_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
  assign drop       = drop_q;
  assign frame_done = frame_done_q;

`ifdef VIDEO_IN_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // One count per cycle carrying any error pulse, saturating.
  always_ff @(posedge clk) begin
    if (RST) begin
      err_cnt_q <= '0;
    end else if ((line_err_q || frame_err_q || drop_q) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
